// File: rtl/vpe_arbiter.sv
// rtl/vpe_arbiter.sv - round-robin arbiter sharing one vector processing engine
//
// Purpose: NUM_REQ special-function sequencers (layernorm, rope, softmax, ...)
// share a single VPE. One operation is in flight at a time. A requester may
// lock the VPE so its next op follows without competition, and a timeout
// answers on behalf of a VPE that never responds.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (ready is one-hot, combinational)
//   req_lock, req_mode        keep-VPE flag, 0 = vec*sca / 1 = vec.*vec
//   req_vec1/req_vec2/req_sca1 packed per-requester operands (requester i at slice i)
//   vpe_vec1/vec2/sca1/mode   registered operands of the granted requester
//   vpe_valid_o               one-cycle start pulse to the VPE
//   vpe_valid_i, res_vpe_*    VPE result handshake and data
//   rsp_valid, rsp_err        one-hot result pulse, timeout qualifier
//   rsp_vec, rsp_sca          result broadcast to all requesters
//   busy, grant_id            not idle, current/last granted requester
module vpe_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int dim_size    = 128,
    parameter int data_width  = 16,
    parameter int TIMEOUT     = 64,
    parameter int LOCK_WINDOW = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ-1:0]                       req_lock,
    input  logic [NUM_REQ-1:0]                       req_mode,
    input  logic [NUM_REQ*dim_size*data_width-1:0]   req_vec1,
    input  logic [NUM_REQ*dim_size*data_width-1:0]   req_vec2,
    input  logic [NUM_REQ*data_width-1:0]            req_sca1,
    output logic [dim_size*data_width-1:0]           vpe_vec1,
    output logic [dim_size*data_width-1:0]           vpe_vec2,
    output logic [data_width-1:0]                    vpe_sca1,
    output logic                                     vpe_mode,
    output logic                                     vpe_valid_o,
    input  logic                                     vpe_valid_i,
    input  logic [dim_size*data_width-1:0]           res_vpe_vec,
    input  logic [data_width-1:0]                    res_vpe_sca,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output logic                                     rsp_err,
    output logic [dim_size*data_width-1:0]           rsp_vec,
    output logic [data_width-1:0]                    rsp_sca,
    output logic                                     busy,
    output logic [$clog2(NUM_REQ)-1:0]               grant_id
);

    localparam int VW = dim_size * data_width;
    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int WW = $clog2(LOCK_WINDOW + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic [VW-1:0]           vec1_q, vec1_d, vec2_q, vec2_d;
    logic [data_width-1:0]   sca1_q, sca1_d;
    logic                    mode_q, mode_d;
    logic [VW-1:0]           rvec_q, rvec_d;
    logic [data_width-1:0]   rsca_q, rsca_d;
    logic                    rerr_q, rerr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_q, last_d;
    logic                    hold_q, hold_d;
    logic                    lock_act_q, lock_act_d;
    logic [GW-1:0]           lock_id_q, lock_id_d;
    logic [WW-1:0]           win_q, win_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;

    logic [NUM_REQ-1:0]      cand;
    logic                    found;
    logic [GW-1:0]           gnt;
    logic [GW-1:0]           idx;
    logic [VW-1:0]           sel_vec1, sel_vec2;
    logic [data_width-1:0]   sel_sca1;
    logic                    sel_mode;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] id);
        logic [NUM_REQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    // Round-robin pick starting just above the last unlocked grant. While a
    // lock is armed only the holder is a candidate.
    always_comb begin
        cand = req_valid;
        if (lock_act_q) begin
            cand = req_valid & onehot(lock_id_q);
        end
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_q) + k) % NUM_REQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_vec1 = '0;
        sel_vec2 = '0;
        sel_sca1 = '0;
        sel_mode = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt == GW'(k)) begin
                sel_vec1 = req_vec1[k*VW +: VW];
                sel_vec2 = req_vec2[k*VW +: VW];
                sel_sca1 = req_sca1[k*data_width +: data_width];
                sel_mode = req_mode[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        vec1_d     = vec1_q;
        vec2_d     = vec2_q;
        sca1_d     = sca1_q;
        mode_d     = mode_q;
        rvec_d     = rvec_q;
        rsca_d     = rsca_q;
        rerr_d     = rerr_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hold_d     = hold_q;
        lock_act_d = lock_act_q;
        lock_id_d  = lock_id_q;
        win_d      = win_q;
        to_cnt_d   = to_cnt_q;
        req_ready  = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready = onehot(gnt);
                    vec1_d    = sel_vec1;
                    vec2_d    = sel_vec2;
                    sca1_d    = sel_sca1;
                    mode_d    = sel_mode;
                    grant_d   = gnt;
                    // A locked grant must not disturb fairness for the others.
                    if (!lock_act_q) begin
                        last_d = gnt;
                    end
                    // The lock is re-armed at RESP only if this op asks for it,
                    // so dropping it here still lets the op finish uncontested.
                    hold_d     = req_lock[gnt];
                    lock_act_d = 1'b0;
                    state_d    = S_ISSUE;
                end else if (lock_act_q) begin
                    // Holder idle this cycle: burn one window cycle.
                    win_d = win_q - WW'(1);
                    if (win_q <= WW'(1)) begin
                        lock_act_d = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (vpe_valid_i) begin
                    rvec_d  = res_vpe_vec;
                    rsca_d  = res_vpe_sca;
                    rerr_d  = 1'b0;
                    state_d = S_RESP;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    rvec_d  = '0;
                    rsca_d  = '0;
                    rerr_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                if (hold_q) begin
                    lock_act_d = 1'b1;
                    lock_id_d  = grant_q;
                    win_d      = WW'(LOCK_WINDOW);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec1_q     <= '0;
            vec2_q     <= '0;
            sca1_q     <= '0;
            mode_q     <= 1'b0;
            rvec_q     <= '0;
            rsca_q     <= '0;
            rerr_q     <= 1'b0;
            grant_q    <= '0;
            last_q     <= GW'(NUM_REQ - 1);
            hold_q     <= 1'b0;
            lock_act_q <= 1'b0;
            lock_id_q  <= '0;
            win_q      <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            vec1_q     <= vec1_d;
            vec2_q     <= vec2_d;
            sca1_q     <= sca1_d;
            mode_q     <= mode_d;
            rvec_q     <= rvec_d;
            rsca_q     <= rsca_d;
            rerr_q     <= rerr_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            lock_act_q <= lock_act_d;
            lock_id_q  <= lock_id_d;
            win_q      <= win_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign vpe_vec1    = vec1_q;
    assign vpe_vec2    = vec2_q;
    assign vpe_sca1    = sca1_q;
    assign vpe_mode    = mode_q;
    assign vpe_valid_o = (state_q == S_ISSUE);
    assign rsp_valid   = (state_q == S_RESP) ? onehot(grant_q) : '0;
    assign rsp_err     = rerr_q;
    assign rsp_vec     = rvec_q;
    assign rsp_sca     = rsca_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_vpe_arbiter.sv
// tb/tb_vpe_arbiter.sv - directed self-checking bench for vpe_arbiter
module tb_vpe_arbiter;

    localparam int NR  = 3;
    localparam int DIM = 4;
    localparam int DW  = 16;
    localparam int VW  = DIM * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_lock, req_mode;
    logic [NR*VW-1:0]  req_vec1, req_vec2;
    logic [NR*DW-1:0]  req_sca1;
    logic [VW-1:0]     vpe_vec1, vpe_vec2;
    logic [DW-1:0]     vpe_sca1;
    logic              vpe_mode, vpe_valid_o, vpe_valid_i;
    logic [VW-1:0]     res_vpe_vec;
    logic [DW-1:0]     res_vpe_sca;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_err;
    logic [VW-1:0]     rsp_vec;
    logic [DW-1:0]     rsp_sca;
    logic              busy;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] sca_tab [NR];

    vpe_arbiter #(
        .NUM_REQ(NR), .dim_size(DIM), .data_width(DW), .TIMEOUT(64), .LOCK_WINDOW(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_mode(req_mode), .req_vec1(req_vec1), .req_vec2(req_vec2),
        .req_sca1(req_sca1), .vpe_vec1(vpe_vec1), .vpe_vec2(vpe_vec2),
        .vpe_sca1(vpe_sca1), .vpe_mode(vpe_mode), .vpe_valid_o(vpe_valid_o),
        .vpe_valid_i(vpe_valid_i), .res_vpe_vec(res_vpe_vec),
        .res_vpe_sca(res_vpe_sca), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_vec(rsp_vec), .rsp_sca(rsp_sca), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec_of(input logic [15:0] base, input int i);
        logic [15:0] e;
        e = base + 16'(i);
        return {e, e, e, e};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One full op: accept in the current IDLE cycle, VPE answers lat cycles
    // after the start pulse. Returns #1 into the first IDLE cycle after RESP.
    task automatic op(input string tag, input int g, input int lat, input logic [VW-1:0] res);
        int t0;
        @(negedge clk);
        check({tag, "_ready"}, 64'(req_ready), 64'(3'b001 << g));
        t0 = cyc;
        @(posedge clk); #1;
        check({tag, "_start"}, 64'(vpe_valid_o), 64'd1);
        check({tag, "_gid"}, 64'(grant_id), 64'(g));
        check({tag, "_sca"}, 64'(vpe_sca1), 64'(sca_tab[g]));
        check({tag, "_mode"}, 64'(vpe_mode), 64'(req_mode[g]));
        check({tag, "_vec1"}, 64'(vpe_vec1), 64'(vec_of(16'h0100, g)));
        check({tag, "_vec2"}, 64'(vpe_vec2), 64'(vec_of(16'h0200, g)));
        @(posedge clk); #1;
        check({tag, "_start1"}, 64'(vpe_valid_o), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        repeat (lat - 1) @(posedge clk);
        #1;
        vpe_valid_i = 1'b1;
        res_vpe_vec = res;
        res_vpe_sca = res[15:0] ^ 16'h5A5A;
        @(posedge clk); #1;
        vpe_valid_i = 1'b0;
        @(negedge clk);
        check({tag, "_rsp"}, 64'(rsp_valid), 64'(3'b001 << g));
        check({tag, "_rvec"}, 64'(rsp_vec), 64'(res));
        check({tag, "_rsca"}, 64'(rsp_sca), 64'(res[15:0] ^ 16'h5A5A));
        check({tag, "_rerr"}, 64'(rsp_err), 64'd0);
        check({tag, "_lat"}, 64'(cyc - t0), 64'(lat + 2));
        @(posedge clk); #1;
        check({tag, "_rsp1"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int early;
        int late;
        sca_tab[0] = 16'h3C00;
        sca_tab[1] = 16'h4000;
        sca_tab[2] = 16'h4200;
        rst = 1'b1;
        req_valid = '0;
        req_lock = '0;
        req_mode = 3'b110;
        vpe_valid_i = 1'b0;
        res_vpe_vec = '0;
        res_vpe_sca = '0;
        for (int i = 0; i < NR; i++) begin
            req_vec1[i*VW +: VW] = vec_of(16'h0100, i);
            req_vec2[i*VW +: VW] = vec_of(16'h0200, i);
            req_sca1[i*DW +: DW] = sca_tab[i];
        end
        do_reset();

        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(vpe_valid_o), 64'd0);
        check("rst_rsp", 64'(rsp_valid), 64'd0);
        check("rst_gid", 64'(grant_id), 64'd0);
        check("rst_sca", 64'(vpe_sca1), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rerr", 64'(rsp_err), 64'd0);
        @(posedge clk); #1;

        // Single request, VPE answers 3 cycles after start.
        req_valid = 3'b001;
        op("single", 0, 3, 64'h1234_5678_9ABC_DEF0);
        req_valid = 3'b000;

        // Round robin from reset with everyone requesting.
        do_reset();
        req_valid = 3'b111;
        op("rr0", 0, 1, 64'h0000_0000_0000_0A0A);
        op("rr1", 1, 2, 64'h0000_0000_0000_1B1B);
        op("rr2", 2, 1, 64'h0000_0000_0000_2C2C);
        op("rr3", 0, 4, 64'h0000_0000_0000_3D3D);

        // Lock: req1 twice back to back, pointer stays at 1.
        req_lock = 3'b010;
        op("lk1a", 1, 1, 64'hAAAA_0000_0000_0001);
        req_lock = 3'b000;
        op("lk1b", 1, 2, 64'hAAAA_0000_0000_0002);
        op("lk2", 2, 1, 64'hAAAA_0000_0000_0003);
        op("lk0", 0, 1, 64'hAAAA_0000_0000_0004);

        // Lock window expiry: req2 locks then goes quiet, req0 waits 8 cycles.
        req_valid = 3'b100;
        req_lock = 3'b100;
        op("win2", 2, 1, 64'hBBBB_0000_0000_0001);
        req_valid = 3'b001;
        req_lock = 3'b000;
        early = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready != 3'b000) early++;
        end
        check("win_held", 64'(early), 64'd0);
        op("win0", 0, 1, 64'hBBBB_0000_0000_0002);
        req_valid = 3'b000;

        // Timeout: VPE silent.
        req_valid = 3'b001;
        @(negedge clk);
        check("to_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(posedge clk); #1;
        early = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rsp_valid != 3'b000) early++;
            @(posedge clk);
        end
        check("to_early", 64'(early), 64'd0);
        @(negedge clk);
        check("to_rsp", 64'(rsp_valid), 64'd1);
        check("to_err", 64'(rsp_err), 64'd1);
        check("to_vec", 64'(rsp_vec), 64'd0);
        check("to_sca", 64'(rsp_sca), 64'd0);
        @(posedge clk); #1;
        vpe_valid_i = 1'b1;
        res_vpe_vec = 64'hDEAD;
        @(posedge clk); #1;
        vpe_valid_i = 1'b0;
        late = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid != 3'b000 || busy) late++;
        end
        check("to_late", 64'(late), 64'd0);

        // Reset in the middle of WAIT.
        @(posedge clk); #1;
        req_valid = 3'b010;
        @(negedge clk);
        check("mr_ready", 64'(req_ready), 64'b010);
        @(posedge clk); #1;
        req_valid = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_start", 64'(vpe_valid_o), 64'd0);
        check("mr_gid", 64'(grant_id), 64'd0);
        check("mr_sca", 64'(vpe_sca1), 64'd0);
        vpe_valid_i = 1'b1;
        @(posedge clk); #1;
        vpe_valid_i = 1'b0;
        late = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid != 3'b000) late++;
        end
        check("mr_norsp", 64'(late), 64'd0);
        @(posedge clk); #1;
        req_valid = 3'b111;
        op("mr0", 0, 1, 64'hCCCC_0000_0000_0001);
        req_valid = 3'b000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
